pyth_trip: RTL and testbench



---
 rtl/pyth_trip_pkg.sv | 24 ++
 rtl/pyth_trip_square.sv | 15 +
 rtl/pyth_trip.sv | 141 ++++++++++++++
 tb/tb_pyth_trip.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyth_trip_pkg.sv
// Shared types, widths and helpers for the pyth_trip error trip/peak block.
package pyth_trip_pkg;

    // Sample sequencing: one shared squarer is walked over I, then Q, then the result is judged.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_I = 2'd1,
        SQ_Q = 2'd2,
        CMP  = 2'd3
    } state_t;

    localparam int MAG_W = 8;
    localparam int SQ_W  = 11;
    localparam int SUM_W = 12;
    localparam int CNT_W = 8;

    // |x| of a 9-bit signed value, saturated to 8 bits (-256 becomes 255).
    function automatic logic [MAG_W-1:0] abs_sat(input logic [8:0] x);
        logic [8:0] a;
        a = x[8] ? (~x + 9'd1) : x;
        return a[8] ? {MAG_W{1'b1}} : a[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/pyth_trip_square.sv
// Combinational squarer: sq = round(v*v / 32), 8-bit in, 11-bit out (max 2032).
module square (
    input  logic [7:0]  v,
    output logic [10:0] sq
);

    logic [15:0] prod;

    // Full product plus half an LSB of the output, then drop the five fractional bits.
    always_comb begin
        prod = 16'(v) * 16'(v);
        sq   = 11'((prod + 16'd16) >> 5);
    end

endmodule

// File: rtl/pyth_trip.sv
// pyth_trip: I/Q error magnitude-squared, run-length trip and peak hold.
// Optional build macro PYTH_TRIP_OVERRUN_EN compiles in sticky overrun detection;
// without it the overrun port is tied low and strobes arriving while busy are dropped silently.
//
// Handshake: strobe is a fire-and-forget valid with no ready; a strobe is accepted only
// when busy is low (state IDLE). A strobe seen while busy is discarded and never queued.
module pyth_trip
    import pyth_trip_pkg::*;
#(
    parameter int TRIP_COUNT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic [8:0]  err_i,
    input  logic [8:0]  err_q,
    input  logic [11:0] threshold,
    input  logic        trip_clear,
    input  logic        peak_clear,
    output logic        busy,
    output logic [11:0] mag2,
    output logic        mag2_valid,
    output logic        trip,
    output logic [11:0] peak,
    output logic        overrun
);

    state_t             state;
    state_t             state_next;
    logic [MAG_W-1:0]   mag_i;
    logic [MAG_W-1:0]   mag_q;
    logic [MAG_W-1:0]   sq_in;
    logic [SQ_W-1:0]    sq;
    logic [SUM_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_new;
    logic               trip_hit;

    // Next-state: a fixed four-step walk started by an accepted strobe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (strobe) state_next = SQ_I;
            SQ_I:    state_next = SQ_Q;
            SQ_Q:    state_next = CMP;
            CMP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; busy is registered so it is glitch-free and equals (state != IDLE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Single squarer shared over both components; the state picks which magnitude feeds it.
    always_comb begin
        sq_in = (state == SQ_Q) ? mag_q : mag_i;
    end

    square u_square (
        .v  (sq_in),
        .sq (sq)
    );

    // Capture magnitudes on an accepted strobe and accumulate the two squares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_i <= '0;
            mag_q <= '0;
            acc   <= '0;
        end else begin
            if (state == IDLE && strobe) begin
                mag_i <= abs_sat(err_i);
                mag_q <= abs_sat(err_q);
            end
            if (state == SQ_I) acc <= SUM_W'(sq);
            if (state == SQ_Q) acc <= acc + SUM_W'(sq);
        end
    end

    // Run counter candidate for this CMP: saturating increment when over threshold, else restart.
    always_comb begin
        cnt_new = '0;
        if (acc > threshold) begin
            cnt_new = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        end
        trip_hit = (cnt_new == CNT_W'(TRIP_COUNT));
    end

    // Result, run counter, trip and peak; a CMP update takes priority over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag2       <= '0;
            mag2_valid <= 1'b0;
            cnt        <= '0;
            trip       <= 1'b0;
            peak       <= '0;
        end else begin
            mag2_valid <= (state == CMP);
            if (state == CMP) begin
                mag2 <= acc;
                cnt  <= cnt_new;
            end else if (trip_clear) begin
                cnt  <= '0;
            end
            if (state == CMP && trip_hit) begin
                trip <= 1'b1;
            end else if (trip_clear) begin
                trip <= 1'b0;
            end
            if (state == CMP) begin
                if (peak_clear || acc > peak) peak <= acc;
            end else if (peak_clear) begin
                peak <= '0;
            end
        end
    end

`ifdef PYTH_TRIP_OVERRUN_EN
    // Sticky flag for strobes that arrive while a sample is in flight; a new drop beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (strobe && state != IDLE) begin
            overrun <= 1'b1;
        end else if (trip_clear) begin
            overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pyth_trip.sv
// Bench for pyth_trip: two instances (trip after 1 and after 3 over-threshold samples) share
// stimulus; expectations come from an arithmetic model of the sample/trip/peak rules.
module tb_pyth_trip;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic [8:0]  err_i;
    logic [8:0]  err_q;
    logic [11:0] threshold;
    logic        trip_clear;
    logic        peak_clear;

    logic        busy_a, valid_a, trip_a, ovr_a;
    logic [11:0] mag2_a, peak_a;
    logic        busy_b, valid_b, trip_b, ovr_b;
    logic [11:0] mag2_b, peak_b;

`ifdef PYTH_TRIP_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    pyth_trip #(.TRIP_COUNT(1)) dut_a (
        .clk(clk), .rst(rst), .strobe(strobe), .err_i(err_i), .err_q(err_q),
        .threshold(threshold), .trip_clear(trip_clear), .peak_clear(peak_clear),
        .busy(busy_a), .mag2(mag2_a), .mag2_valid(valid_a), .trip(trip_a),
        .peak(peak_a), .overrun(ovr_a)
    );

    pyth_trip #(.TRIP_COUNT(3)) dut_b (
        .clk(clk), .rst(rst), .strobe(strobe), .err_i(err_i), .err_q(err_q),
        .threshold(threshold), .trip_clear(trip_clear), .peak_clear(peak_clear),
        .busy(busy_b), .mag2(mag2_b), .mag2_valid(valid_b), .trip(trip_b),
        .peak(peak_b), .overrun(ovr_b)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mag2, m_peak, m_cnt1, m_cnt3;
    bit m_trip1, m_trip3, m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mag_of(input int x);
        int a;
        a = (x < 0) ? -x : x;
        return (a > 255) ? 255 : a;
    endfunction

    // round(a^2 / 32), half rounds up
    function automatic int sq_of(input int a);
        return (a * a + 16) / 32;
    endfunction

    function automatic int run_step(input int c, input bit over);
        if (!over) return 0;
        return (c < 255) ? c + 1 : 255;
    endfunction

    task automatic model_reset();
        m_mag2 = 0; m_peak = 0; m_cnt1 = 0; m_cnt3 = 0;
        m_trip1 = 0; m_trip3 = 0; m_ovr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_static(input string tag);
        check({tag, "_mag2"},  32'(mag2_a), 32'(m_mag2));
        check({tag, "_peak"},  32'(peak_a), 32'(m_peak));
        check({tag, "_trip1"}, 32'(trip_a), 32'(m_trip1));
        check({tag, "_ovr"},   32'(ovr_a),  32'(m_ovr));
        check({tag, "_mag2b"}, 32'(mag2_b), 32'(m_mag2));
        check({tag, "_peakb"}, 32'(peak_b), 32'(m_peak));
        check({tag, "_trip3"}, 32'(trip_b), 32'(m_trip3));
        check({tag, "_ovrb"},  32'(ovr_b),  32'(m_ovr));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("idle_busy",  32'(busy_a),  0);
            check("idle_valid", 32'(valid_a), 0);
            check("idle_busyb", 32'(busy_b),  0);
            check_static("idle");
        end
    endtask

    task automatic pulse_clear(input bit tc, input bit pc);
        trip_clear = tc;
        peak_clear = pc;
        tick();
        trip_clear = 1'b0;
        peak_clear = 1'b0;
        if (tc) begin
            m_trip1 = 0; m_trip3 = 0; m_cnt1 = 0; m_cnt3 = 0; m_ovr = 0;
        end
        if (pc) m_peak = 0;
        check("clr_busy", 32'(busy_a), 0);
        check_static("clr");
    endtask

    // Driver: one sample with strobe in cycle N; ends in cycle N+4, where a new strobe may start.
    task automatic do_sample(input int i, input int q, input int thr,
                             input bit dup, input bit tclr2, input bit tclr3, input bit pclr3);
        int acc;
        bit over;
        int n1, n3;
        err_i     = 9'(i);
        err_q     = 9'(q);
        threshold = 12'($urandom_range(0, 4095));
        strobe    = 1'b1;
        tick();                                  // N+1
        strobe = 1'b0;
        check("n1_busy",  32'(busy_a),  1);
        check("n1_busyb", 32'(busy_b),  1);
        check("n1_valid", 32'(valid_a), 0);
        err_i = 9'($urandom_range(0, 511));
        err_q = 9'($urandom_range(0, 511));
        tick();                                  // N+2
        check("n2_busy", 32'(busy_a), 1);
        strobe     = dup;
        trip_clear = tclr2;
        tick();                                  // N+3 (CMP)
        strobe     = 1'b0;
        trip_clear = 1'b0;
        if (tclr2) begin
            m_trip1 = 0; m_trip3 = 0; m_cnt1 = 0; m_cnt3 = 0; m_ovr = 0;
        end
        if (dup && OVR_EN) m_ovr = 1;
        check("n3_busy",  32'(busy_a),  1);
        check("n3_valid", 32'(valid_a), 0);
        check("n3_ovr",   32'(ovr_a),   32'(m_ovr));
        threshold  = 12'(thr);
        trip_clear = tclr3;
        peak_clear = pclr3;
        tick();                                  // N+4
        trip_clear = 1'b0;
        peak_clear = 1'b0;
        acc  = sq_of(mag_of(i)) + sq_of(mag_of(q));
        over = (acc > thr);
        n1   = run_step(m_cnt1, over);
        n3   = run_step(m_cnt3, over);
        if (tclr3) begin
            m_trip1 = 0; m_trip3 = 0; m_ovr = 0;
        end
        m_cnt1 = n1;
        m_cnt3 = n3;
        if (n1 == 1) m_trip1 = 1;
        if (n3 == 3) m_trip3 = 1;
        m_mag2 = acc;
        m_peak = (pclr3 || acc > m_peak) ? acc : m_peak;
        check("n4_valid",  32'(valid_a), 1);
        check("n4_validb", 32'(valid_b), 1);
        check("n4_busy",   32'(busy_a),  0);
        check_static("n4");
    endtask

    task automatic reset_mid_sample();
        err_i  = 9'd100;
        err_q  = 9'd50;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();                                  // mid-sample
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_busy",  32'(busy_a),  0);
        check("rst_valid", 32'(valid_a), 0);
        check_static("rst_mid");
        tick();
        rst = 1'b0;
        idle_cycles(5);
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; err_i = '0; err_q = '0; threshold = '0;
        trip_clear = 1'b0; peak_clear = 1'b0;
        model_reset();
        repeat (3) tick();
        check_static("in_reset");
        rst = 1'b0;
        idle_cycles(20);

        // 128,128 -> 512+512
        do_sample(128, 128, 2000, 0, 0, 0, 0);
        check("basic_mag2", 32'(mag2_a), 1024);
        check("basic_peak", 32'(peak_a), 1024);
        check("basic_trip", 32'(trip_a), 0);
        idle_cycles(1);

        // Full-scale: -256 saturates to 255
        do_sample(-256, 255, 4000, 0, 0, 0, 0);
        check("full_mag2", 32'(mag2_a), 4064);
        check("full_trip", 32'(trip_a), 1);
        do_sample(0, 0, 4000, 0, 0, 0, 0);       // strobe exactly at N+4
        check("zero_mag2", 32'(mag2_a), 0);
        check("zero_trip", 32'(trip_a), 1);
        check("zero_peak", 32'(peak_a), 4064);
        idle_cycles(2);

        // Run of three over-threshold samples for the TRIP_COUNT=3 instance
        pulse_clear(1, 0);
        do_sample(128, 128, 1000, 0, 0, 0, 0);
        do_sample(128, 128, 1000, 0, 0, 0, 0);
        do_sample(0, 0, 1000, 0, 0, 0, 0);
        do_sample(128, 128, 1000, 0, 0, 0, 0);
        do_sample(128, 128, 1000, 0, 0, 0, 0);
        check("run_fifth", 32'(trip_b), 0);
        do_sample(128, 128, 1000, 0, 0, 0, 0);
        check("run_sixth", 32'(trip_b), 1);
        idle_cycles(2);

        // Dropped strobe at N+2
        do_sample(10, -10, 4095, 1, 0, 0, 0);
        check("dup_ovr", 32'(ovr_a), 32'(OVR_EN));
        idle_cycles(3);
        pulse_clear(1, 0);
        check("dup_ovr_clr", 32'(ovr_a), 0);

        // Peak clear coincident with CMP, trip clear coincident with tripping CMP
        do_sample(-256, -256, 0, 0, 0, 0, 0);
        check("pk_full", 32'(peak_a), 4064);
        pulse_clear(1, 0);
        do_sample(128, 0, 4000, 0, 0, 0, 1);
        check("pk_clr_cmp", 32'(peak_a), 512);
        do_sample(-256, 255, 4000, 0, 0, 1, 0);
        check("tclr_cmp_trip", 32'(trip_a), 1);
        // Trip clear coincident with a dropped strobe: the drop wins
        do_sample(3, 4, 4095, 1, 1, 0, 0);
        check("tclr_dup_ovr", 32'(ovr_a), 32'(OVR_EN));
        idle_cycles(1);
        pulse_clear(0, 1);

        reset_mid_sample();

        // Randomized samples with occasional clears, drops and gaps
        for (int r = 0; r < 80; r++) begin
            int ri, rq, rthr;
            ri   = int'($urandom_range(0, 511)) - 256;
            rq   = int'($urandom_range(0, 511)) - 256;
            rthr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1500))
                                              : int'($urandom_range(0, 4095));
            do_sample(ri, rq, rthr,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 9) == 0) pulse_clear($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
